// File: rtl/int_to_int_array_pipe.sv
// LANES-wide INT-to-INT lane converter (16/32-bit, signed/unsigned, saturate or wrap)
// with a valid/ready pipeline of 2+PIPE_EXTRA stages and a sticky saturation status bit.
module int_to_int_array_pipe #(
  parameter int LANES      = 4,
  parameter int PIPE_EXTRA = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [32*LANES-1:0] dvr_inttoint_s_in,
  input  logic [7:0]         cru_inttoint_in,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [32*LANES-1:0] dr_inttoint_d_out,
  output logic [LANES-1:0]   sat_flag,
  output logic               sat_sticky,
  input  logic               sat_clr
);

  localparam int W    = 32 * LANES;
  localparam int NSTG = 2 + PIPE_EXTRA;

  typedef struct packed {
    logic sat_en;
    logic instr_vld;
    logic dst_prec;
    logic dst_signed;
    logic dst_pos;
  } ctrl_t;

  logic [NSTG-1:0]   vld_q;
  logic [NSTG-1:0]   rdy;
  logic              all_full;

  logic signed [32:0] ext_d [LANES];
  logic signed [32:0] ext_q [LANES];
  ctrl_t              ctrl_q;

  logic [W-1:0]      res_d;
  logic [LANES-1:0]  flag_d;
  logic [W-1:0]      res_q  [PIPE_EXTRA+1];
  logic [LANES-1:0]  flag_q [PIPE_EXTRA+1];

  logic [31:0]        src_word;
  logic [15:0]        src_half;
  logic signed [32:0] lane_v;
  logic signed [32:0] lane_hi;
  logic signed [32:0] lane_lo;
  logic [31:0]        lane_r;
  logic [31:0]        lane_placed;
  logic               lane_sat;

  // A stage may load when it is empty or every stage downstream of it can shift.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rdy      = '0;
    all_full = 1'b1;
    for (int i = NSTG - 1; i >= 0; i--) begin
      all_full = all_full & vld_q[i];
      rdy[i]   = out_rdy | ~all_full;
    end
  end

  assign in_rdy = rst_n & rdy[0];

  // Stage 1 input: pick the source field and extend it to a 33-bit signed value.
  always_comb begin
    src_word = '0;
    src_half = '0;
    for (int l = 0; l < LANES; l++) begin
      src_word = dvr_inttoint_s_in[W-1-32*l -: 32];
      src_half = cru_inttoint_in[1] ? src_word[31:16] : src_word[15:0];
      if (cru_inttoint_in[5])
        ext_d[l] = cru_inttoint_in[3] ? {src_word[31], src_word} : {1'b0, src_word};
      else
        ext_d[l] = cru_inttoint_in[3] ? {{17{src_half[15]}}, src_half} : {17'b0, src_half};
    end
  end

  // NOTE: datapath registers carry no reset; the valid bits alone decide what is meaningful.
  always_ff @(posedge clk) begin
    if (rdy[0] && in_vld) begin
      ext_q  <= ext_d;
      ctrl_q <= '{sat_en:     cru_inttoint_in[7],
                  instr_vld:  cru_inttoint_in[6],
                  dst_prec:   cru_inttoint_in[4],
                  dst_signed: cru_inttoint_in[2],
                  dst_pos:    cru_inttoint_in[0]};
    end
  end

  // Stage 2 input: range check, clamp or wrap, then place into the destination half.
  always_comb begin
    res_d       = '0;
    flag_d      = '0;
    lane_v      = '0;
    lane_hi     = '0;
    lane_lo     = '0;
    lane_r      = '0;
    lane_placed = '0;
    lane_sat    = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      lane_v = ext_q[l];
      case ({ctrl_q.dst_prec, ctrl_q.dst_signed})
        2'b11:   begin lane_hi = 33'sh0_7FFF_FFFF; lane_lo = 33'sh1_8000_0000; end
        2'b10:   begin lane_hi = 33'sh0_FFFF_FFFF; lane_lo = 33'sh0_0000_0000; end
        2'b01:   begin lane_hi = 33'sh0_0000_7FFF; lane_lo = 33'sh1_FFFF_8000; end
        default: begin lane_hi = 33'sh0_0000_FFFF; lane_lo = 33'sh0_0000_0000; end
      endcase
      lane_r   = lane_v[31:0];
      lane_sat = 1'b0;
      if (ctrl_q.sat_en && (lane_v > lane_hi || lane_v < lane_lo)) begin
        lane_r   = (lane_v > lane_hi) ? lane_hi[31:0] : lane_lo[31:0];
        lane_sat = 1'b1;
      end
      if (ctrl_q.dst_prec)
        lane_placed = lane_r;
      else if (ctrl_q.dst_pos)
        lane_placed = {lane_r[15:0], 16'h0000};
      else
        lane_placed = {16'h0000, lane_r[15:0]};
      if (!ctrl_q.instr_vld) begin
        lane_placed = '0;
        lane_sat    = 1'b0;
      end
      res_d[W-1-32*l -: 32] = lane_placed;
      flag_d[l]             = lane_sat;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage shifts from pre-edge values.
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k <= PIPE_EXTRA; k++) begin
        res_q[k]  <= '0;
        flag_q[k] <= '0;
      end
    end else begin
      if (rdy[0]) vld_q[0] <= in_vld;
      for (int i = 1; i < NSTG; i++)
        if (rdy[i]) vld_q[i] <= vld_q[i-1];
      if (rdy[1] && vld_q[0]) begin
        res_q[0]  <= res_d;
        flag_q[0] <= flag_d;
      end
      for (int k = 1; k <= PIPE_EXTRA; k++) begin
        if (rdy[k+1] && vld_q[k]) begin
          res_q[k]  <= res_q[k-1];
          flag_q[k] <= flag_q[k-1];
        end
      end
    end
  end

  assign out_vld           = vld_q[NSTG-1];
  assign dr_inttoint_d_out = res_q[PIPE_EXTRA];
  assign sat_flag          = flag_q[PIPE_EXTRA];

  // Set takes priority over clear so a saturation in the clearing cycle is not lost.
  always_ff @(posedge clk) begin
    if (!rst_n)
      sat_sticky <= 1'b0;
    else if (out_vld && out_rdy && |sat_flag)
      sat_sticky <= 1'b1;
    else if (sat_clr)
      sat_sticky <= 1'b0;
  end

endmodule

// File: tb/tb_int_to_int_array_pipe.sv
// Self-checking bench: directed scenarios on a 4-lane instance, lane-order and random
// stream checks on an 8-lane instance with one extra output stage.
module tb_int_to_int_array_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_vld, in_rdy, out_vld, out_rdy, sticky, sat_clr;
  logic [127:0] s_in, d_out;
  logic [7:0]   cru;
  logic [3:0]   flag;

  logic         in_vld8, in_rdy8, out_vld8, out_rdy8, sticky8, sat_clr8;
  logic [255:0] s_in8, d_out8;
  logic [7:0]   cru8;
  logic [7:0]   flag8;

  int errors = 0;
  int checks = 0;

  int_to_int_array_pipe #(.LANES(4), .PIPE_EXTRA(0)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
    .dvr_inttoint_s_in(s_in), .cru_inttoint_in(cru), .out_vld(out_vld),
    .out_rdy(out_rdy), .dr_inttoint_d_out(d_out), .sat_flag(flag),
    .sat_sticky(sticky), .sat_clr(sat_clr));

  int_to_int_array_pipe #(.LANES(8), .PIPE_EXTRA(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld8), .in_rdy(in_rdy8),
    .dvr_inttoint_s_in(s_in8), .cru_inttoint_in(cru8), .out_vld(out_vld8),
    .out_rdy(out_rdy8), .dr_inttoint_d_out(d_out8), .sat_flag(flag8),
    .sat_sticky(sticky8), .sat_clr(sat_clr8));

  typedef struct { logic [127:0] d; logic [3:0] f; } exp4_t;
  typedef struct { logic [255:0] d; logic [7:0] f; } exp8_t;

  // Reference for one lane from the conversion rules: returns {flag, 32-bit result}.
  function automatic logic [32:0] ref_lane(input logic [31:0] w, input logic [7:0] c);
    longint v, hi, lo, r;
    int bits;
    logic [15:0] h;
    logic f;
    logic [31:0] res;
    if (!c[6]) return 33'd0;
    if (c[5]) v = c[3] ? longint'($signed(w)) : longint'({32'h0, w});
    else begin
      h = c[1] ? w[31:16] : w[15:0];
      v = c[3] ? longint'($signed(h)) : longint'({48'h0, h});
    end
    bits = c[4] ? 32 : 16;
    if (c[2]) begin
      hi = (64'sd1 <<< (bits - 1)) - 1;
      lo = -(64'sd1 <<< (bits - 1));
    end else begin
      hi = (64'sd1 <<< bits) - 1;
      lo = 0;
    end
    f = 1'b0;
    r = v;
    if ((v > hi || v < lo) && c[7]) begin
      r = (v > hi) ? hi : lo;
      f = 1'b1;
    end
    res = c[4] ? r[31:0] : (c[0] ? {r[15:0], 16'h0} : {16'h0, r[15:0]});
    return {f, res};
  endfunction

  function automatic exp4_t ref4(input logic [127:0] b, input logic [7:0] c);
    exp4_t e;
    logic [32:0] t;
    for (int l = 0; l < 4; l++) begin
      t = ref_lane(b[32*(3-l) +: 32], c);
      e.d[32*(3-l) +: 32] = t[31:0];
      e.f[l] = t[32];
    end
    return e;
  endfunction

  function automatic exp8_t ref8(input logic [255:0] b, input logic [7:0] c);
    exp8_t e;
    logic [32:0] t;
    for (int l = 0; l < 8; l++) begin
      t = ref_lane(b[32*(7-l) +: 32], c);
      e.d[32*(7-l) +: 32] = t[31:0];
      e.f[l] = t[32];
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_word();
    logic [31:0] edges [8];
    edges = '{32'h0000_7FFF, 32'h0000_8000, 32'h0000_FFFF, 32'h0001_0000,
              32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    case ($urandom % 4)
      0:       return $urandom;
      1:       return {16'h0, 16'($urandom)};
      2:       return {16'hFFFF, 16'($urandom)};
      default: return edges[$urandom % 8];
    endcase
  endfunction

  task automatic idle_inputs();
    in_vld = 1'b0;  out_rdy = 1'b1;  sat_clr = 1'b0;  s_in = '0;  cru = '0;
    in_vld8 = 1'b0; out_rdy8 = 1'b1; sat_clr8 = 1'b0; s_in8 = '0; cru8 = '0;
  endtask

  // Drives one beat into the 4-lane DUT and records what is seen 1 and 2 cycles later.
  task automatic send_one(input logic [127:0] data, input logic [7:0] c,
                          output logic acc, output logic vld1, output logic vld2,
                          output logic [127:0] d, output logic [3:0] f);
    @(negedge clk);
    in_vld = 1'b1; s_in = data; cru = c; out_rdy = 1'b1;
    #1 acc = in_rdy;
    @(negedge clk);
    in_vld = 1'b0; s_in = '0;
    #1 vld1 = out_vld;
    @(negedge clk);
    #1 vld2 = out_vld; d = d_out; f = flag;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld got=%b exp=0", out_vld); end
    checks++; if (d_out !== 128'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", d_out); end
    checks++; if (flag !== 4'h0) begin errors++; $display("FAIL reset_flag got=%b exp=0", flag); end
    checks++; if (sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got=%b exp=0", sticky); end
    checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL reset_in_rdy_low got=%b exp=0", in_rdy); end
    checks++; if (out_vld8 !== 1'b0) begin errors++; $display("FAIL reset_out_vld8 got=%b exp=0", out_vld8); end
    rst_n = 1'b1;
    #1;
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy_high got=%b exp=1", in_rdy); end
  endtask

  task automatic test_sat_s32_s16();
    logic acc, v1, v2; logic [127:0] d; logic [3:0] f;
    send_one({32'h0001_2345, 96'h0}, 8'hEC, acc, v1, v2, d, f);
    checks++; if (acc !== 1'b1) begin errors++; $display("FAIL sat_accept got=%b exp=1", acc); end
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL sat_latency1 got=%b exp=0", v1); end
    checks++; if (v2 !== 1'b1) begin errors++; $display("FAIL sat_latency2 got=%b exp=1", v2); end
    checks++; if (d !== {32'h0000_7FFF, 96'h0}) begin errors++; $display("FAIL sat_data got=%h exp=%h", d, {32'h0000_7FFF, 96'h0}); end
    checks++; if (f !== 4'b0001) begin errors++; $display("FAIL sat_flag got=%b exp=0001", f); end
    @(negedge clk);
    checks++; if (sticky !== 1'b1) begin errors++; $display("FAIL sat_sticky got=%b exp=1", sticky); end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL sat_no_dup got=%b exp=0", out_vld); end
  endtask

  task automatic test_wrap();
    logic acc, v1, v2; logic [127:0] d; logic [3:0] f;
    send_one({32'h0001_2345, 96'h0}, 8'h6C, acc, v1, v2, d, f);
    checks++; if (d !== {32'h0000_2345, 96'h0}) begin errors++; $display("FAIL wrap_data got=%h exp=%h", d, {32'h0000_2345, 96'h0}); end
    checks++; if (f !== 4'b0000) begin errors++; $display("FAIL wrap_flag got=%b exp=0000", f); end
    @(negedge clk);
    checks++; if (sticky !== 1'b1) begin errors++; $display("FAIL wrap_sticky_kept got=%b exp=1", sticky); end
  endtask

  task automatic test_u16_to_s32();
    logic acc, v1, v2; logic [127:0] d; logic [3:0] f;
    send_one({32'hFFFF_0000, 32'h1234_5678, 64'h0}, 8'hD6, acc, v1, v2, d, f);
    checks++; if (d !== {32'h0000_FFFF, 32'h0000_1234, 64'h0}) begin errors++; $display("FAIL u16_s32_data got=%h exp=%h", d, {32'h0000_FFFF, 32'h0000_1234, 64'h0}); end
    checks++; if (f !== 4'b0000) begin errors++; $display("FAIL u16_s32_flag got=%b exp=0000", f); end
  endtask

  task automatic test_s16_to_u32();
    logic acc, v1, v2; logic [127:0] d; logic [3:0] f;
    send_one({32'h0000_8000, 64'h0, 32'h0000_7FFF}, 8'hD8, acc, v1, v2, d, f);
    checks++; if (d !== {96'h0, 32'h0000_7FFF}) begin errors++; $display("FAIL s16_u32_data got=%h exp=%h", d, {96'h0, 32'h0000_7FFF}); end
    checks++; if (f !== 4'b0001) begin errors++; $display("FAIL s16_u32_flag got=%b exp=0001", f); end
  endtask

  task automatic test_instr_invalid();
    logic acc, v1, v2; logic [127:0] d; logic [3:0] f;
    send_one({4{32'h8001_2345}}, 8'hAC, acc, v1, v2, d, f);
    checks++; if (v2 !== 1'b1) begin errors++; $display("FAIL noinstr_out_vld got=%b exp=1", v2); end
    checks++; if (d !== 128'h0) begin errors++; $display("FAIL noinstr_data got=%h exp=0", d); end
    checks++; if (f !== 4'b0000) begin errors++; $display("FAIL noinstr_flag got=%b exp=0000", f); end
  endtask

  task automatic test_back_pressure();
    logic [127:0] data [6];
    logic [7:0]   cr [6];
    exp4_t q[$];
    exp4_t e;
    int sent = 0;
    int got = 0;
    for (int i = 0; i < 6; i++) begin
      data[i] = {rand_word(), rand_word(), rand_word(), rand_word()};
      cr[i] = 8'($urandom) | 8'h40;
    end
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      in_vld = (sent < 6);
      if (sent < 6) begin s_in = data[sent]; cru = cr[sent]; end
      out_rdy = !(c >= 3 && c <= 6);
      #1;
      if (c == 3) begin
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL bp_full_in_rdy got=%b exp=0", in_rdy); end
      end
      if (c == 7) begin
        checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL bp_resume_in_rdy got=%b exp=1", in_rdy); end
      end
      if (out_vld) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL bp_unexpected_beat got=%h exp=none", d_out);
        end else begin
          e = q[0];
          if (d_out !== e.d || flag !== e.f) begin
            errors++; $display("FAIL bp_data got=%h/%b exp=%h/%b", d_out, flag, e.d, e.f);
          end
          if (out_rdy) begin q.delete(0); got++; end
        end
      end
      if (in_vld && in_rdy) begin q.push_back(ref4(data[sent], cr[sent])); sent++; end
    end
    in_vld = 1'b0;
    checks++; if (got !== 6) begin errors++; $display("FAIL bp_count got=%0d exp=6", got); end
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL bp_pending got=%0d exp=0", q.size()); end
  endtask

  task automatic test_reset_midflight();
    logic acc, v1, v2; logic [127:0] d; logic [3:0] f;
    @(negedge clk);
    out_rdy = 1'b0; in_vld = 1'b1; s_in = {4{32'h0001_0000}}; cru = 8'hEC;
    @(negedge clk);
    s_in = {4{32'h0002_0000}};
    @(negedge clk);
    in_vld = 1'b0;
    #1;
    checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL rst_mid_inflight got=%b exp=1", out_vld); end
    checks++; if (sticky !== 1'b1) begin errors++; $display("FAIL rst_mid_sticky_pre got=%b exp=1", sticky); end
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rst_mid_out_vld got=%b exp=0", out_vld); end
    checks++; if (d_out !== 128'h0) begin errors++; $display("FAIL rst_mid_data got=%h exp=0", d_out); end
    checks++; if (sticky !== 1'b0) begin errors++; $display("FAIL rst_mid_sticky got=%b exp=0", sticky); end
    rst_n = 1'b1; out_rdy = 1'b1;
    send_one({32'h0001_2345, 96'h0}, 8'hEC, acc, v1, v2, d, f);
    checks++; if (v1 !== 1'b0 || v2 !== 1'b1) begin errors++; $display("FAIL rst_mid_latency got=%b%b exp=01", v1, v2); end
    checks++; if (d !== {32'h0000_7FFF, 96'h0}) begin errors++; $display("FAIL rst_mid_first_beat got=%h exp=%h", d, {32'h0000_7FFF, 96'h0}); end
    @(negedge clk);
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL rst_mid_no_stale got=%b exp=0", out_vld); end
  endtask

  task automatic test_sticky_clr();
    @(negedge clk);
    sat_clr = 1'b1;
    @(negedge clk);
    sat_clr = 1'b0;
    checks++; if (sticky !== 1'b0) begin errors++; $display("FAIL clr_initial got=%b exp=0", sticky); end
    in_vld = 1'b1; s_in = {32'h0001_0000, 96'h0}; cru = 8'hEC;
    @(negedge clk);
    in_vld = 1'b0;
    @(negedge clk);
    sat_clr = 1'b1;
    #1;
    checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL clr_beat_vld got=%b exp=1", out_vld); end
    @(negedge clk);
    checks++; if (sticky !== 1'b1) begin errors++; $display("FAIL clr_set_wins got=%b exp=1", sticky); end
    @(negedge clk);
    sat_clr = 1'b0;
    checks++; if (sticky !== 1'b0) begin errors++; $display("FAIL clr_alone got=%b exp=0", sticky); end
  endtask

  task automatic test_lanes8();
    logic [255:0] data, exp_d;
    for (int l = 0; l < 8; l++) begin
      data[32*(7-l) +: 32]  = 32'(l + 1);
      exp_d[32*(7-l) +: 32] = 32'(l + 1);
    end
    data[32*(7-5) +: 32] = 32'h0001_0000; exp_d[32*(7-5) +: 32] = 32'h0000_7FFF;
    data[32*(7-2) +: 32] = 32'hFFF0_0000; exp_d[32*(7-2) +: 32] = 32'h0000_8000;
    @(negedge clk);
    in_vld8 = 1'b1; s_in8 = data; cru8 = 8'hEC; out_rdy8 = 1'b1;
    @(negedge clk);
    in_vld8 = 1'b0;
    #1;
    checks++; if (out_vld8 !== 1'b0) begin errors++; $display("FAIL l8_latency1 got=%b exp=0", out_vld8); end
    @(negedge clk);
    checks++; if (out_vld8 !== 1'b0) begin errors++; $display("FAIL l8_latency2 got=%b exp=0", out_vld8); end
    @(negedge clk);
    sat_clr8 = 1'b1;
    #1;
    checks++; if (out_vld8 !== 1'b1) begin errors++; $display("FAIL l8_latency3 got=%b exp=1", out_vld8); end
    checks++; if (d_out8 !== exp_d) begin errors++; $display("FAIL l8_data got=%h exp=%h", d_out8, exp_d); end
    checks++; if (flag8 !== 8'b0010_0100) begin errors++; $display("FAIL l8_flag got=%b exp=00100100", flag8); end
    @(negedge clk);
    checks++; if (sticky8 !== 1'b1) begin errors++; $display("FAIL l8_set_wins got=%b exp=1", sticky8); end
    @(negedge clk);
    sat_clr8 = 1'b0;
    checks++; if (sticky8 !== 1'b0) begin errors++; $display("FAIL l8_clr got=%b exp=0", sticky8); end
  endtask

  task automatic test_random8();
    exp8_t q[$];
    exp8_t e;
    logic  sticky_m = 1'b0;
    logic  xfer;
    for (int c = 0; c < 450; c++) begin
      @(negedge clk);
      if (c < 400) begin
        in_vld8 = ($urandom % 4) != 0;
        for (int l = 0; l < 8; l++) s_in8[32*l +: 32] = rand_word();
        cru8 = 8'($urandom);
        cru8[6] = ($urandom % 8) != 0;
        out_rdy8 = ($urandom % 3) != 0;
      end else begin
        in_vld8 = 1'b0;
        out_rdy8 = 1'b1;
      end
      sat_clr8 = ($urandom % 8) == 0;
      #1;
      checks++; if (sticky8 !== sticky_m) begin errors++; $display("FAIL rnd_sticky cyc=%0d got=%b exp=%b", c, sticky8, sticky_m); end
      xfer = 1'b0;
      e.f = '0;
      if (out_vld8) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rnd_unexpected_beat cyc=%0d got=%h exp=none", c, d_out8);
        end else begin
          e = q[0];
          if (d_out8 !== e.d || flag8 !== e.f) begin
            errors++; $display("FAIL rnd_data cyc=%0d got=%h/%b exp=%h/%b", c, d_out8, flag8, e.d, e.f);
          end
          if (out_rdy8) begin q.delete(0); xfer = 1'b1; end
        end
      end
      if (xfer && |e.f) sticky_m = 1'b1;
      else if (sat_clr8) sticky_m = 1'b0;
      if (in_vld8 && in_rdy8) q.push_back(ref8(s_in8, cru8));
    end
    in_vld8 = 1'b0; sat_clr8 = 1'b0;
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL rnd_pending got=%0d exp=0", q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_sat_s32_s16();
    test_wrap();
    test_u16_to_s32();
    test_s16_to_u32();
    test_instr_invalid();
    test_back_pressure();
    test_reset_midflight();
    test_sticky_clr();
    test_lanes8();
    test_random8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
